dif_pair_buffer: RTL and testbench
==================================

# dif_pair_buffer

Input commutator for one DIF FFT stage. It takes a serial complex sample stream and buffers the first half of each stage-length block. It then presents each buffered sample together with its partner from the second half as a simultaneous L/R pair. Its outputs drive the L/R inputs and valid of the stage butterfly directly downstream. One instance is placed in front of each butterfly stage.

## Interface
- IN_W, 10, bit width of each I and Q component, signed two's complement.
- STAGE, 0, stage index, same meaning as the butterfly it feeds.
- TOTAL_STAGES, 8, log2 of the full FFT length.
- Derived, not overridable:
  - HALF = 2**(TOTAL_STAGES-STAGE-1).
  - CNT_W = TOTAL_STAGES-STAGE.
- Legal range: STAGE ≤ TOTAL_STAGES-1, so HALF ≥ 1.

Ports:
- mclk  in  1  clock; all logic on the rising edge.
- i_init_n  in  1  asynchronous active-low reset.
- i_vld  in  1  input sample valid; gaps of any length allowed; no backpressure.
- i_sof  in  1  start of block; sampled only when i_vld=1.
- i_I  in  IN_W  input in-phase sample.
- i_Q  in  IN_W  input quadrature sample.
- o_vld  out  1  pair valid, single-cycle strobe per pair.
- o_sof  out  1  first pair of a block; only asserted with o_vld.
- o_LI, o_LQ  out  IN_W  first-half (buffered) sample.
- o_RI, o_RQ  out  IN_W  second-half (live) sample.
- o_resync_strb  out  1  one-cycle strobe: i_sof arrived mid-block; independent of o_vld.

## Operation
- pos is a CNT_W-bit position counter for the current block, range 0..2*HALF-1.
  - phase = pos[CNT_W-1]: 0 = FILL, 1 = PAIR.
  - addr = pos[CNT_W-2:0]. When HALF=1, addr is absent and the buffer is a single register.
- Effective position eff = (i_vld & i_sof) ? 0 : pos.
- On every i_vld:
  - FILL (eff < HALF): write {i_I,i_Q} to buf[eff]. No output.
  - PAIR (eff ≥ HALF): read buf[eff-HALF] in the same cycle, combinationally. Register it to o_LI/o_LQ, register the live sample to o_RI/o_RQ, and pulse o_vld.
  - pos <= eff+1, wrapping 2*HALF-1 → 0. Blocks follow back to back without needing i_sof.
- o_sof is set when the pair is produced at eff == HALF.
- Resync: i_vld & i_sof with pos != 0 gives:
  - pos is forced per eff, so this sample is written as buf[0].
  - the partially collected block is discarded; none of its pairs are emitted.
  - o_resync_strb pulses one cycle later.
  - i_sof at pos == 0 is legal and silent.
- i_sof without i_vld is ignored.
- When i_vld=0: pos, buffer and output data regs hold; o_vld, o_sof and o_resync_strb are 0.
- The buffer is HALF x 2*IN_W. It is not reset and is never read before being written within a block.
- No arithmetic is performed; the data path is pure pass-through at IN_W.

## Timing
- Reset values: o_vld=0, o_sof=0, o_resync_strb=0, o_LI/o_LQ/o_RI/o_RQ=0, pos=0 (FILL).
- Reset assertion is asynchronous and takes effect immediately. Deassertion is synchronised externally.
- Latency: o_vld rises on the edge after the i_vld cycle carrying a second-half sample, i.e. 1 cycle.
- Output data holds until the next pair.
- Throughput: one sample per cycle sustained. A full block of 2*HALF consecutive i_vld yields HALF consecutive o_vld cycles, starting HALF+1 cycles after the block's first sample.
- Reset mid-block: the partial block is discarded and the next sample goes to buf[0]. A pair pending in the output register is cleared.
- i_sof on the same cycle as a wrap (pos==0) produces no strobe.
- Reset mid-frame with i_vld high: the first valid sample after deassertion is position 0.

## Test plan
- N=8 (TOTAL_STAGES=3, STAGE=0, HALF=4):
  - Stimulus: I=1..8 and Q=-1..-8 on consecutive cycles, i_sof on the first.
  - Required: pairs L/R (1,5),(2,6),(3,7),(4,8), with Q negated likewise.
  - o_vld high on cycles 5–8 after the first sample; o_sof with the first pair only.
- Same config, two back-to-back blocks (16 samples), i_sof only on sample 1:
  - Required: 8 pairs; second block pairs (9,13)..(12,16); o_sof on pairs 1 and 5.
- Gapped input: i_vld toggles 1,0,1,0 over 16 cycles carrying 1..8.
  - Required: identical pair values; o_vld never high on cycles after i_vld=0.
  - Output data stable between strobes.
- Resync: feed 1,2,3, then 10..17 with i_sof on 10.
  - Required: o_resync_strb pulses once, one cycle after sample 10.
  - Pairs are (10,14)..(13,17); values 1–3 never appear.
- Reset: assert i_init_n=0 after 6 samples (during PAIR, one pair already pending).
  - Required: all outputs 0 immediately.
  - Then 8 fresh samples give the correct 4 pairs with o_sof on the first.
- Edge config STAGE=TOTAL_STAGES-1 (HALF=1):
  - Stimulus: samples 7, -3, 4, 2.
  - Required: pairs (7,-3),(4,2); o_sof on both.

Source files
------------

// File: rtl/dif_pair_buffer.sv
// dif_pair_buffer: input commutator for one DIF FFT stage.
// Buffers the first half of each 2*HALF-sample block and, during the second
// half, presents each buffered sample (L) with its live partner (R) as one
// registered pair for the downstream butterfly.
module dif_pair_buffer #(
   parameter int IN_W         = 10,
   parameter int STAGE        = 0,
   parameter int TOTAL_STAGES = 8
) (
   input  logic            mclk,
   input  logic            i_init_n,
   input  logic            i_vld,
   input  logic            i_sof,
   input  logic [IN_W-1:0] i_I,
   input  logic [IN_W-1:0] i_Q,
   output logic            o_vld,
   output logic            o_sof,
   output logic [IN_W-1:0] o_LI,
   output logic [IN_W-1:0] o_LQ,
   output logic [IN_W-1:0] o_RI,
   output logic [IN_W-1:0] o_RQ,
   output logic            o_resync_strb
);

   localparam int HALF   = 2**(TOTAL_STAGES-STAGE-1);
   localparam int CNT_W  = TOTAL_STAGES-STAGE;
   // With HALF=1 there is no address field; a 1-bit constant-zero index keeps
   // the single-entry buffer addressable without a zero-width vector.
   localparam int ADDR_W = (CNT_W > 1) ? CNT_W-1 : 1;

   logic [CNT_W-1:0]  pos_q, pos_d;
   logic              vld_q, vld_d;
   logic              sof_q, sof_d;
   logic              resync_q, resync_d;
   logic [IN_W-1:0]   li_q, li_d, lq_q, lq_d, ri_q, ri_d, rq_q, rq_d;

   logic [CNT_W-1:0]  eff;
   logic              phase;
   logic [ADDR_W-1:0] addr;
   logic [2*IN_W-1:0] rd_data;

   // First-half sample store, {I,Q} per entry; deliberately not reset.
   logic [2*IN_W-1:0] pair_mem [HALF];

   // A valid i_sof restarts the block at position 0 in the same cycle.
   assign eff   = (i_vld && i_sof) ? '0 : pos_q;
   assign phase = eff[CNT_W-1];

   if (CNT_W > 1) begin : g_addr
      assign addr = eff[CNT_W-2:0];
   end else begin : g_no_addr
      assign addr = '0;
   end

   assign rd_data = pair_mem[addr];

   // Next-state: advance position, form pair and strobes on each valid sample.
   always_comb begin
      pos_d    = pos_q;
      vld_d    = 1'b0;
      sof_d    = 1'b0;
      resync_d = 1'b0;
      li_d     = li_q;
      lq_d     = lq_q;
      ri_d     = ri_q;
      rq_d     = rq_q;
      if (i_vld) begin
         // 2*HALF equals 2**CNT_W, so the counter wraps on its own.
         pos_d    = eff + CNT_W'(1);
         resync_d = i_sof && (pos_q != '0);
         if (phase) begin
            vld_d = 1'b1;
            sof_d = (addr == '0);
            li_d  = rd_data[2*IN_W-1:IN_W];
            lq_d  = rd_data[IN_W-1:0];
            ri_d  = i_I;
            rq_d  = i_Q;
         end
      end
   end

   // State and output registers; reset clears any pending pair.
   always_ff @(posedge mclk or negedge i_init_n) begin
      if (!i_init_n) begin
         pos_q    <= '0;
         vld_q    <= 1'b0;
         sof_q    <= 1'b0;
         resync_q <= 1'b0;
         li_q     <= '0;
         lq_q     <= '0;
         ri_q     <= '0;
         rq_q     <= '0;
      end else begin
         pos_q    <= pos_d;
         vld_q    <= vld_d;
         sof_q    <= sof_d;
         resync_q <= resync_d;
         li_q     <= li_d;
         lq_q     <= lq_d;
         ri_q     <= ri_d;
         rq_q     <= rq_d;
      end
   end

   // Capture first-half samples; contents only matter once written in a block.
   always_ff @(posedge mclk) begin
      if (i_vld && !phase) begin
         pair_mem[addr] <= {i_I, i_Q};
      end
   end

   assign o_vld         = vld_q;
   assign o_sof         = sof_q;
   assign o_resync_strb = resync_q;
   assign o_LI          = li_q;
   assign o_LQ          = lq_q;
   assign o_RI          = ri_q;
   assign o_RQ          = rq_q;

endmodule

// File: tb/tb_dif_pair_buffer.sv
// Directed bench for dif_pair_buffer: HALF=4 instance driven from a vector
// table plus hand-written reset sequence, and a HALF=1 instance.
module tb_dif_pair_buffer;

   logic       mclk;
   logic       i_init_n;

   logic       i_vld, i_sof;
   logic [9:0] i_I, i_Q;
   logic       o_vld, o_sof, o_resync_strb;
   logic [9:0] o_LI, o_LQ, o_RI, o_RQ;

   logic       i1_vld, i1_sof;
   logic [9:0] i1_I, i1_Q;
   logic       o1_vld, o1_sof, o1_resync_strb;
   logic [9:0] o1_LI, o1_LQ, o1_RI, o1_RQ;

   int checks;
   int failures;

   dif_pair_buffer #(.IN_W(10), .STAGE(0), .TOTAL_STAGES(3)) u_dut4 (
      .mclk(mclk), .i_init_n(i_init_n),
      .i_vld(i_vld), .i_sof(i_sof), .i_I(i_I), .i_Q(i_Q),
      .o_vld(o_vld), .o_sof(o_sof),
      .o_LI(o_LI), .o_LQ(o_LQ), .o_RI(o_RI), .o_RQ(o_RQ),
      .o_resync_strb(o_resync_strb)
   );

   dif_pair_buffer #(.IN_W(10), .STAGE(2), .TOTAL_STAGES(3)) u_dut1 (
      .mclk(mclk), .i_init_n(i_init_n),
      .i_vld(i1_vld), .i_sof(i1_sof), .i_I(i1_I), .i_Q(i1_Q),
      .o_vld(o1_vld), .o_sof(o1_sof),
      .o_LI(o1_LI), .o_LQ(o1_LQ), .o_RI(o1_RI), .o_RQ(o1_RQ),
      .o_resync_strb(o1_resync_strb)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   typedef struct {
      logic       vld;
      logic       sof;
      logic [9:0] i;
      logic [9:0] q;
      logic [42:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [42:0] pack_exp(input logic v, input logic s, input logic r,
                                            input int l, input int rr);
      logic [9:0] li, lq, ri, rq;
      li = 10'(l);
      lq = 10'(-l);
      ri = 10'(rr);
      rq = 10'(-rr);
      return {v, s, r, li, lq, ri, rq};
   endfunction

   // Q of every sample and pair is the negated I value.
   task automatic add(input logic v, input logic s, input int i,
                      input logic ev, input logic es, input logic er,
                      input int l, input int r);
      vec_t t;
      t.vld = v;
      t.sof = s;
      t.i   = 10'(i);
      t.q   = 10'(-i);
      t.exp = pack_exp(ev, es, er, l, r);
      tbl.push_back(t);
   endtask

   task automatic check(input string nm, input logic [42:0] act, input logic [42:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got vld/sof/rs=%b%b%b L=%h,%h R=%h,%h required vld/sof/rs=%b%b%b L=%h,%h R=%h,%h",
                  nm, act[42], act[41], act[40], act[39:30], act[29:20], act[19:10], act[9:0],
                  exp[42], exp[41], exp[40], exp[39:30], exp[29:20], exp[19:10], exp[9:0]);
      end
   endtask

   function automatic logic [42:0] act4();
      return {o_vld, o_sof, o_resync_strb, o_LI, o_LQ, o_RI, o_RQ};
   endfunction

   function automatic logic [42:0] act1();
      return {o1_vld, o1_sof, o1_resync_strb, o1_LI, o1_LQ, o1_RI, o1_RQ};
   endfunction

   task automatic drive4(input logic v, input logic s, input int i);
      i_vld = v;
      i_sof = s;
      i_I   = 10'(i);
      i_Q   = 10'(-i);
   endtask

   task automatic drive1(input logic v, input logic s, input int i);
      i1_vld = v;
      i1_sof = s;
      i1_I   = 10'(i);
      i1_Q   = 10'(-i);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      drive4(0, 0, 0);
      drive1(0, 0, 0);

      // Two back-to-back blocks, i_sof on sample 1 only.
      add(1,1, 1, 0,0,0, 0, 0);
      add(1,0, 2, 0,0,0, 0, 0);
      add(1,0, 3, 0,0,0, 0, 0);
      add(1,0, 4, 0,0,0, 0, 0);
      add(1,0, 5, 1,1,0, 1, 5);
      add(1,0, 6, 1,0,0, 2, 6);
      add(1,0, 7, 1,0,0, 3, 7);
      add(1,0, 8, 1,0,0, 4, 8);
      add(1,0, 9, 0,0,0, 4, 8);
      add(1,0,10, 0,0,0, 4, 8);
      add(1,0,11, 0,0,0, 4, 8);
      add(1,0,12, 0,0,0, 4, 8);
      add(1,0,13, 1,1,0, 9,13);
      add(1,0,14, 1,0,0,10,14);
      add(1,0,15, 1,0,0,11,15);
      add(1,0,16, 1,0,0,12,16);
      // Gapped input; idle cycles sometimes carry a stray i_sof.
      add(1,1, 1, 0,0,0,12,16);
      add(0,1,99, 0,0,0,12,16);
      add(1,0, 2, 0,0,0,12,16);
      add(0,0,99, 0,0,0,12,16);
      add(1,0, 3, 0,0,0,12,16);
      add(0,1,99, 0,0,0,12,16);
      add(1,0, 4, 0,0,0,12,16);
      add(0,0,99, 0,0,0,12,16);
      add(1,0, 5, 1,1,0, 1, 5);
      add(0,1,99, 0,0,0, 1, 5);
      add(1,0, 6, 1,0,0, 2, 6);
      add(0,0,99, 0,0,0, 2, 6);
      add(1,0, 7, 1,0,0, 3, 7);
      add(0,1,99, 0,0,0, 3, 7);
      add(1,0, 8, 1,0,0, 4, 8);
      add(0,0,99, 0,0,0, 4, 8);
      // i_sof at pos 0 is silent; i_sof on sample 10 resyncs mid-block.
      add(1,1, 1, 0,0,0, 4, 8);
      add(1,0, 2, 0,0,0, 4, 8);
      add(1,0, 3, 0,0,0, 4, 8);
      add(1,1,10, 0,0,1, 4, 8);
      add(1,0,11, 0,0,0, 4, 8);
      add(1,0,12, 0,0,0, 4, 8);
      add(1,0,13, 0,0,0, 4, 8);
      add(1,0,14, 1,1,0,10,14);
      add(1,0,15, 1,0,0,11,15);
      add(1,0,16, 1,0,0,12,16);
      add(1,0,17, 1,0,0,13,17);

      i_init_n = 1'b0;
      #2;
      check("reset_h4", act4(), 43'd0);
      check("reset_h1", act1(), 43'd0);
      @(negedge mclk);
      i_init_n = 1'b1;

      for (int k = 0; k < tbl.size(); k++) begin
         @(negedge mclk);
         drive4(tbl[k].vld, tbl[k].sof, int'($signed(tbl[k].i)));
         @(posedge mclk);
         #1;
         check($sformatf("vec%0d", k), act4(), tbl[k].exp);
      end

      // Reset during PAIR phase with a pair pending in the output register.
      for (int k = 0; k < 6; k++) begin
         @(negedge mclk);
         drive4(1, k == 0, 21 + k);
         @(posedge mclk);
      end
      #1;
      check("pending_pair", act4(), pack_exp(1, 0, 0, 22, 26));
      @(negedge mclk);
      drive4(1, 0, 27);
      #2;
      i_init_n = 1'b0;
      #1;
      check("async_reset", act4(), 43'd0);
      @(posedge mclk);
      #1;
      check("reset_held", act4(), 43'd0);
      @(negedge mclk);
      i_init_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) @(negedge mclk);
         drive4(1, 0, 31 + k);
         @(posedge mclk);
         #1;
         if (k < 4)
            check($sformatf("post_reset%0d", k), act4(), 43'd0);
         else
            check($sformatf("post_reset%0d", k), act4(),
                  pack_exp(1, k == 4, 0, 31 + k - 4, 35 + k - 4));
      end
      @(negedge mclk);
      drive4(0, 0, 0);

      // HALF=1 instance: every pair is the first pair of its block.
      @(negedge mclk);
      drive1(1, 1, 7);
      @(posedge mclk); #1;
      check("h1_s0", act1(), 43'd0);
      @(negedge mclk);
      drive1(1, 0, -3);
      @(posedge mclk); #1;
      check("h1_p0", act1(), pack_exp(1, 1, 0, 7, -3));
      @(negedge mclk);
      drive1(1, 0, 4);
      @(posedge mclk); #1;
      check("h1_s1", act1(), pack_exp(0, 0, 0, 7, -3));
      @(negedge mclk);
      drive1(1, 0, 2);
      @(posedge mclk); #1;
      check("h1_p1", act1(), pack_exp(1, 1, 0, 4, 2));
      @(negedge mclk);
      drive1(0, 0, 0);
      @(posedge mclk); #1;
      check("h1_idle", act1(), pack_exp(0, 0, 0, 4, 2));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
